// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing constants and parameter checks for i2s_tx_param.
// I2S_TX_LJ_EN selects left-justified framing (no one-bit delay).
package i2s_pkg;
`ifdef I2S_TX_LJ_EN
  localparam int LOAD_BIT = 0;
`else
  localparam int LOAD_BIT = 1;
`endif
  function automatic int frame_bits(input int slot_bits);
    return 2 * slot_bits;
  endfunction
  function automatic bit params_ok(input int sample_w, input int slot_bits, input int mclk_div, input int sclk_div);
    return sample_w >= 1 && sample_w <= slot_bits && mclk_div >= 2 && mclk_div % 2 == 0 &&
           sclk_div >= 2 && sclk_div % 2 == 0;
  endfunction
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: MCLK and SCLK dividers plus the frame bit counter.
module i2s_clk_gen #(
  parameter int MCLK_DIV  = 8,
  parameter int SCLK_DIV  = 32,
  parameter int SLOT_BITS = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           mclk_o,
  output logic                           sclk_o,
  output logic                           lrclk_o,
  output logic                           shift_evt_o,
  output logic [$clog2(2*SLOT_BITS)-1:0] bit_cnt_o
);
  localparam int MW = $clog2(MCLK_DIV);
  localparam int SW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(2*SLOT_BITS);
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [SW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic mclk_q, sclk_q;
  assign shift_evt_o = div_q == SW'(SCLK_DIV-1);
  always_comb begin
    mcnt_d = (mcnt_q == MW'(MCLK_DIV-1)) ? '0 : mcnt_q + 1'b1;
    div_d  = shift_evt_o ? '0 : div_q + 1'b1;
    bit_d  = !shift_evt_o ? bit_q : (bit_q == BW'(2*SLOT_BITS-1)) ? '0 : bit_q + 1'b1;
  end
  // Clocks are registered from the next count so they align with the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcnt_q <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      mclk_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      mcnt_q <= mcnt_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      mclk_q <= mcnt_d >= MW'(MCLK_DIV/2);
      sclk_q <= div_d >= SW'(SCLK_DIV/2);
    end
  end
  assign mclk_o    = mclk_q;
  assign sclk_o    = sclk_q;
  assign lrclk_o   = bit_q >= BW'(SLOT_BITS);
  assign bit_cnt_o = bit_q;
endmodule

// File: rtl/i2s_tx_param.sv
// i2s_tx_param: parametrised I2S transmitter with one-entry sample holding register.
// Define I2S_TX_LJ_EN for left-justified framing instead of standard I2S.
module i2s_tx_param
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_BITS = 32,
  parameter int MCLK_DIV  = 8,
  parameter int SCLK_DIV  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                MCLK,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDIN,
  output logic                frame_tick,
  output logic                underrun
);
  localparam int FRAME_BITS = frame_bits(SLOT_BITS);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int PAD = SLOT_BITS - SAMPLE_W;
  localparam logic [BW-1:0] PRE_LOAD = BW'((LOAD_BIT + FRAME_BITS - 1) % FRAME_BITS);
  if (!params_ok(SAMPLE_W, SLOT_BITS, MCLK_DIV, SCLK_DIV)) begin : g_bad_params
    $error("i2s_tx_param: illegal parameter combination");
  end
  logic shift_evt, load, accept;
  logic [BW-1:0] bit_cnt;
  logic full_q, full_d, sdin_q, sdin_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d, ld_frame;
  i2s_clk_gen #(
    .MCLK_DIV (MCLK_DIV),
    .SCLK_DIV (SCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .mclk_o     (MCLK),
    .sclk_o     (SCLK),
    .lrclk_o    (LRCLK),
    .shift_evt_o(shift_evt),
    .bit_cnt_o  (bit_cnt)
  );
  assign accept = sample_valid && !full_q;
  assign load   = shift_evt && bit_cnt == PRE_LOAD;
  // The load shift emits the new frame's MSB directly; the frame register keeps the rest.
  always_comb begin
    ld_frame = full_q ? {SLOT_BITS'(hold_l_q) << PAD, SLOT_BITS'(hold_r_q) << PAD} : '0;
    frame_d  = load ? ld_frame << 1 : shift_evt ? frame_q << 1 : frame_q;
    sdin_d   = load ? ld_frame[FRAME_BITS-1] : shift_evt ? frame_q[FRAME_BITS-1] : sdin_q;
    full_d   = accept || (full_q && !load);
    hold_l_d = accept ? sample_l : hold_l_q;
    hold_r_d = accept ? sample_r : hold_r_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= 1'b0;
      sdin_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      frame_q  <= '0;
    end else begin
      full_q   <= full_d;
      sdin_q   <= sdin_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      frame_q  <= frame_d;
    end
  end
  assign sample_ready = !full_q;
  assign SDIN         = sdin_q;
  assign frame_tick   = load;
  assign underrun     = load && !full_q;
endmodule

// File: tb/tb_i2s_tx_param.sv
// tb_i2s_tx_param: scoreboard bench for i2s_tx_param (8-bit samples, 8-bit slots, SCLK_DIV=4, MCLK_DIV=2).
module tb_i2s_tx_param;
`ifdef I2S_TX_LJ_EN
  localparam int LOADN = 63;
`else
  localparam int LOADN = 3;
`endif
  logic clk = 0, rst = 1, sv = 0;
  logic [7:0] sl = 0, sr = 0;
  logic ready, mclk, sclk, lrclk, sdin, tick, urun;
  logic ready6, mclk6, sclk6, lrclk6, sdin6, tick6, urun6;
  int total = 0, bad = 0, cyc = 0, cnt = 0, cnt6 = 0;
  logic [15:0] pend[$], expq[$];
  logic [15:0] cap = 0, cap6 = 0;
  logic prev = 0, prev6 = 0;
  bit primed = 0, ld, full0;

  always #5 clk = ~clk;

  i2s_tx_param #(.SAMPLE_W(8), .SLOT_BITS(8), .MCLK_DIV(2), .SCLK_DIV(4)) u_dut (
    .clk(clk), .reset(rst), .sample_l(sl), .sample_r(sr), .sample_valid(sv),
    .sample_ready(ready), .MCLK(mclk), .SCLK(sclk), .LRCLK(lrclk), .SDIN(sdin),
    .frame_tick(tick), .underrun(urun)
  );

  i2s_tx_param #(.SAMPLE_W(6), .SLOT_BITS(8), .MCLK_DIV(2), .SCLK_DIV(4)) u_dut6 (
    .clk(clk), .reset(rst), .sample_l(6'h3F), .sample_r(6'h15), .sample_valid(1'b1),
    .sample_ready(ready6), .MCLK(mclk6), .SCLK(sclk6), .LRCLK(lrclk6), .SDIN(sdin6),
    .frame_tick(tick6), .underrun(urun6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: cycle index since reset drives clocks and load points; queues carry data.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cyc = 0; cnt = 0; cnt6 = 0; primed = 0; prev = 0; prev6 = 0; cap = 0; cap6 = 0;
      pend.delete(); expq.delete();
    end else begin
      ld = (cyc % 64) == LOADN;
      full0 = pend.size() != 0;
      check("ready", ready, !full0);
      check("tick", tick, ld);
      check("underrun", urun, ld && !full0);
      check("mclk", mclk, (cyc % 2) == 1);
      check("sclk", sclk, (cyc % 4) >= 2);
      check("lrclk", lrclk, ((cyc / 4) % 16) >= 8);
      check("tick6", tick6, ld);
      check("underrun6", urun6, 0);
      check("lrclk6", lrclk6, ((cyc / 4) % 16) >= 8);
      if (cyc == 0) check("sdin_rst", sdin, 0);
      if (sclk && !prev) begin cap = {cap[14:0], sdin}; cnt++; end
      if (sclk6 && !prev6) begin cap6 = {cap6[14:0], sdin6}; cnt6++; end
      prev = sclk;
      prev6 = sclk6;
      if (ld) begin
        if (primed) begin
          check("bits", cnt, 16);
          check("frame", cap, expq.pop_front());
          check("frame6", cap6, 16'hFC54);
        end
        primed = 1; cnt = 0; cnt6 = 0;
        expq.push_back(full0 ? pend.pop_front() : 16'h0);
      end
      if (sv && !full0) pend.push_back({sl, sr});
      cyc++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] l, input logic [7:0] r);
    bit acc = 0;
    sl = l; sr = r; sv = 1;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", acc, 1);
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 200 && (cyc % 64) != ph; i++) wait_cyc(1);
    check("align", cyc % 64, ph);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(2);
    rst = 0;
    wait_cyc(140);
    send(8'hA5, 8'h3C);
    sv = 0;
    wait_cyc(150);
    for (int i = 0; i < 6; i++) send(8'(i * 37 + 1), 8'(~(i * 37 + 1)));
    sv = 0;
    wait_cyc(200);
    wait_phase(LOADN);
    sl = 8'h5A; sr = 8'hC3; sv = 1;
    wait_cyc(1);
    sv = 0;
    wait_cyc(150);
    send(8'hF0, 8'h0F);
    sv = 0;
    wait_phase(40);
    rst = 1;
    wait_cyc(1);
    rst = 0;
    send(8'h81, 8'h7E);
    sv = 0;
    wait_cyc(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
